// File: rtl/tl_pkg.sv
// Shared constants and word layout for the transaction-layer arbiter slice.
package tl_pkg;

  localparam int unsigned DATA_WIDTH = 10;
  localparam int unsigned NUM_VC     = 4;
  localparam int unsigned DEST_MSB   = 9;
  localparam int unsigned DEST_LSB   = 8;
  localparam int unsigned IDX_W      = 2;

  localparam logic [3:0] STATE_RESET  = 4'b0001;
  localparam logic [3:0] STATE_ACTIVE = 4'b0010;

  typedef struct packed {
    logic [DEST_MSB-DEST_LSB:0] dest;
    logic [DEST_LSB-1:0]        payload;
  } tl_word_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_priority_picker
  import tl_pkg::*;
(
  input  logic [NUM_VC-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_VC-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    found     = 1'b0;
    idx       = rr_ptr;
    for (int unsigned k = 0; k < NUM_VC; k++) begin
      idx = rr_ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter draining four FWFT input FIFOs into four output FIFOs by destination.
module arbitro_rr
  import tl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [3:0]            state,
  input  logic [NUM_VC-1:0]     fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data0,
  input  logic [DATA_WIDTH-1:0] fifo_data1,
  input  logic [DATA_WIDTH-1:0] fifo_data2,
  input  logic [DATA_WIDTH-1:0] fifo_data3,
  input  logic [NUM_VC-1:0]     out_almost_full,
  output logic [NUM_VC-1:0]     pop,
  output logic [NUM_VC-1:0]     push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  idle
);

  tl_word_t              head [NUM_VC];
  tl_word_t              gnt_word;
  logic                  active;
  logic [NUM_VC-1:0]     req;
  logic [NUM_VC-1:0]     grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  gnt_any;

  logic [NUM_VC-1:0]     push_d,     push_q;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic [IDX_W-1:0]      rr_ptr_d,   rr_ptr_q;
  logic                  idle_d,     idle_q;

  always_comb begin
    head[0] = tl_word_t'(fifo_data0);
    head[1] = tl_word_t'(fifo_data1);
    head[2] = tl_word_t'(fifo_data2);
    head[3] = tl_word_t'(fifo_data3);
  end

  assign active = (state == STATE_ACTIVE);

  // An input competes only if its head word's destination can accept it.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      req[i] = active && !fifo_empty[i] && !out_almost_full[head[i].dest];
    end
  end

  rr_priority_picker u_picker (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign gnt_any  = |grant;
  assign gnt_word = head[grant_idx];
  assign pop      = reset_L ? grant : '0;

  always_comb begin
    push_d     = '0;
    data_out_d = data_out_q;
    rr_ptr_d   = rr_ptr_q;
    idle_d     = active && (&fifo_empty);
    if (gnt_any) begin
      push_d[gnt_word.dest] = 1'b1;
      data_out_d            = DATA_WIDTH'(gnt_word);
      rr_ptr_d              = grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_q     <= '0;
      data_out_q <= '0;
      rr_ptr_q   <= '0;
      idle_q     <= 1'b0;
    end else begin
      push_q     <= push_d;
      data_out_q <= data_out_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_q     <= idle_d;
    end
  end

  assign push     = push_q;
  assign data_out = data_out_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed self-checking bench for the round-robin arbiter.
module tb_arbitro_rr;
  import tl_pkg::*;

  logic                  clk;
  logic                  reset_L;
  logic [3:0]            state;
  logic [NUM_VC-1:0]     fifo_empty;
  logic [DATA_WIDTH-1:0] fd0, fd1, fd2, fd3;
  logic [NUM_VC-1:0]     out_almost_full;
  logic [NUM_VC-1:0]     pop;
  logic [NUM_VC-1:0]     push;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  idle;

  int passed = 0;
  int total  = 0;

  arbitro_rr dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .state           (state),
    .fifo_empty      (fifo_empty),
    .fifo_data0      (fd0),
    .fifo_data1      (fd1),
    .fifo_data2      (fd2),
    .fifo_data3      (fd3),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    step();
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    state      = STATE_RESET;
    fifo_empty = 4'b0000;
    fd0 = 10'h011; fd1 = 10'h022; fd2 = 10'h033; fd3 = 10'h044;
    out_almost_full = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) reset_L = 1'b1;
      step();
      total++; if (pop !== 4'b0000) $display("FAIL reset_pop c%0d got %b exp 0000", c, pop); else passed++;
      total++; if (push !== 4'b0000) $display("FAIL reset_push c%0d got %b exp 0000", c, push); else passed++;
      total++; if (data_out !== 10'h000) $display("FAIL reset_data c%0d got %h exp 000", c, data_out); else passed++;
      total++; if (idle !== 1'b0) $display("FAIL reset_idle c%0d got %b exp 0", c, idle); else passed++;
    end
  endtask

  task automatic test_single();
    do_reset();
    state      = STATE_ACTIVE;
    fifo_empty = 4'b1110;
    fd0        = 10'b0100000011;
    #1;
    total++; if (pop !== 4'b0001) $display("FAIL single_pop got %b exp 0001", pop); else passed++;
    step();
    fifo_empty = 4'b1111;
    total++; if (push !== 4'b0010) $display("FAIL single_push got %b exp 0010", push); else passed++;
    total++; if (data_out !== 10'b0100000011) $display("FAIL single_data got %h exp 103", data_out); else passed++;
    #1;
    total++; if (pop !== 4'b0000) $display("FAIL single_pop_after got %b exp 0000", pop); else passed++;
    step();
    total++; if (push !== 4'b0000) $display("FAIL single_push_clr got %b exp 0000", push); else passed++;
    total++; if (data_out !== 10'h103) $display("FAIL single_data_hold got %h exp 103", data_out); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop [5];
    logic [9:0] exp_dat [5];
    exp_pop[0] = 4'b0001; exp_pop[1] = 4'b0010; exp_pop[2] = 4'b0100;
    exp_pop[3] = 4'b1000; exp_pop[4] = 4'b0001;
    exp_dat[0] = 10'h010; exp_dat[1] = 10'h021; exp_dat[2] = 10'h032;
    exp_dat[3] = 10'h043; exp_dat[4] = 10'h010;
    do_reset();
    state = STATE_ACTIVE;
    fd0 = 10'h010; fd1 = 10'h021; fd2 = 10'h032; fd3 = 10'h043;
    fifo_empty = 4'b0000;
    out_almost_full = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (pop !== exp_pop[k]) $display("FAIL rr_pop k%0d got %b exp %b", k, pop, exp_pop[k]); else passed++;
      step();
      total++; if (push !== 4'b0001) $display("FAIL rr_push k%0d got %b exp 0001", k, push); else passed++;
      total++; if (data_out !== exp_dat[k]) $display("FAIL rr_data k%0d got %h exp %h", k, data_out, exp_dat[k]); else passed++;
    end
  endtask

  // Runs right after test_round_robin, which leaves the pointer at 1.
  task automatic test_backpressure();
    fd1 = 10'b1000000010;
    fd2 = 10'b0000000100;
    fifo_empty      = 4'b1001;
    out_almost_full = 4'b0100;
    #1;
    total++; if (pop !== 4'b0100) $display("FAIL bp_skip_pop got %b exp 0100", pop); else passed++;
    step();
    total++; if (push !== 4'b0001) $display("FAIL bp_skip_push got %b exp 0001", push); else passed++;
    total++; if (data_out !== 10'h004) $display("FAIL bp_skip_data got %h exp 004", data_out); else passed++;
    fifo_empty = 4'b1101;
    #1;
    total++; if (pop !== 4'b0000) $display("FAIL bp_wait_pop got %b exp 0000", pop); else passed++;
    step();
    total++; if (push !== 4'b0000) $display("FAIL bp_wait_push got %b exp 0000", push); else passed++;
    total++; if (data_out !== 10'h004) $display("FAIL bp_wait_data got %h exp 004", data_out); else passed++;
    out_almost_full = 4'b0000;
    #1;
    total++; if (pop !== 4'b0010) $display("FAIL bp_rel_pop got %b exp 0010", pop); else passed++;
    step();
    fifo_empty = 4'b1111;
    total++; if (push !== 4'b0100) $display("FAIL bp_rel_push got %b exp 0100", push); else passed++;
    total++; if (data_out !== 10'h202) $display("FAIL bp_rel_data got %h exp 202", data_out); else passed++;
  endtask

  task automatic test_state_exit();
    do_reset();
    state = STATE_ACTIVE;
    out_almost_full = 4'b0000;
    fd2 = 10'h3AB;
    fifo_empty = 4'b1011;
    #1;
    total++; if (pop !== 4'b0100) $display("FAIL exit_pop got %b exp 0100", pop); else passed++;
    step();
    state = STATE_RESET;
    #1;
    total++; if (pop !== 4'b0000) $display("FAIL exit_pop_gated got %b exp 0000", pop); else passed++;
    total++; if (push !== 4'b1000) $display("FAIL exit_push_inflight got %b exp 1000", push); else passed++;
    total++; if (data_out !== 10'h3AB) $display("FAIL exit_data got %h exp 3ab", data_out); else passed++;
    step();
    total++; if (push !== 4'b0000) $display("FAIL exit_push_clr got %b exp 0000", push); else passed++;
    total++; if (data_out !== 10'h3AB) $display("FAIL exit_data_hold got %h exp 3ab", data_out); else passed++;
    fifo_empty = 4'b1111;
  endtask

  task automatic test_async_reset();
    do_reset();
    state = STATE_ACTIVE;
    out_almost_full = 4'b0000;
    fd0 = 10'h0F1; fd1 = 10'h1F2; fd2 = 10'h2F3; fd3 = 10'h3F4;
    fifo_empty = 4'b0000;
    #1;
    total++; if (pop !== 4'b0001) $display("FAIL ar_pop0 got %b exp 0001", pop); else passed++;
    step();
    total++; if (push !== 4'b0001) $display("FAIL ar_push0 got %b exp 0001", push); else passed++;
    total++; if (data_out !== 10'h0F1) $display("FAIL ar_data0 got %h exp 0f1", data_out); else passed++;
    #2;
    reset_L = 1'b0;
    #1;
    total++; if (push !== 4'b0000) $display("FAIL ar_push_async got %b exp 0000", push); else passed++;
    total++; if (data_out !== 10'h000) $display("FAIL ar_data_async got %h exp 000", data_out); else passed++;
    total++; if (pop !== 4'b0000) $display("FAIL ar_pop_forced got %b exp 0000", pop); else passed++;
    step();
    total++; if (push !== 4'b0000) $display("FAIL ar_push_held got %b exp 0000", push); else passed++;
    reset_L = 1'b1;
    #1;
    total++; if (pop !== 4'b0001) $display("FAIL ar_restart_pop got %b exp 0001", pop); else passed++;
    step();
    total++; if (push !== 4'b0001) $display("FAIL ar_restart_push got %b exp 0001", push); else passed++;
    total++; if (data_out !== 10'h0F1) $display("FAIL ar_restart_data got %h exp 0f1", data_out); else passed++;
    fifo_empty = 4'b1111;
  endtask

  task automatic test_idle();
    do_reset();
    state = STATE_ACTIVE;
    fifo_empty = 4'b1111;
    out_almost_full = 4'b0000;
    total++; if (idle !== 1'b0) $display("FAIL idle_after_reset got %b exp 0", idle); else passed++;
    step();
    total++; if (idle !== 1'b1) $display("FAIL idle_set got %b exp 1", idle); else passed++;
    total++; if (pop !== 4'b0000) $display("FAIL idle_pop got %b exp 0000", pop); else passed++;
    fd2 = 10'h005;
    fifo_empty = 4'b1011;
    #1;
    total++; if (idle !== 1'b1) $display("FAIL idle_still got %b exp 1", idle); else passed++;
    step();
    fifo_empty = 4'b1111;
    total++; if (idle !== 1'b0) $display("FAIL idle_clr got %b exp 0", idle); else passed++;
    total++; if (push !== 4'b0001) $display("FAIL idle_push got %b exp 0001", push); else passed++;
  endtask

  initial begin
    reset_L = 1'b0;
    state = STATE_RESET;
    fifo_empty = 4'b1111;
    out_almost_full = 4'b0000;
    fd0 = '0; fd1 = '0; fd2 = '0; fd3 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_state_exit();
    test_async_reset();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
